multi_cache_miss_ctrl: RTL and testbench

Parametrised successor to the per-cache miss FSMs. One controller serves N_CH cache channels (instruction, data, future ports) that share a single AXI read/write master.
- Hits are resolved locally with an LRU update.
- Misses are queued per channel and granted round-robin.
- Each granted miss runs write-back (if dirty), then refill, then update.
- Refill beats are counted against BURST_LEN, and burst-length violations are flagged.

---
 rtl/mcm_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/multi_cache_miss_ctrl.sv | 121 ++++++++++++
 tb/tb_multi_cache_miss_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcm_pkg.sv
// Shared types and defaults for the multi-channel cache miss controller.
package mcm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_START,
    S_WB_WAIT,
    S_RD_START,
    S_RD_WAIT,
    S_UPDATE
  } state_e;

  localparam int unsigned N_CH_DEF      = 2;
  localparam int unsigned BURST_LEN_DEF = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping to the lowest index when nothing at or above the pointer requests.
module rr_arbiter #(
  parameter  int unsigned N    = 2,
  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            valid_o
);

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    valid_o  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid_o && req_i[i] && (ID_W'(i) >= ptr_i)) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        gnt_id_o = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid_o && req_i[i]) begin
        valid_o  = 1'b1;
        gnt_o[i] = 1'b1;
        gnt_id_o = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/multi_cache_miss_ctrl.sv
// Shared miss controller: N_CH cache channels queue misses that are served
// round-robin over one AXI master (write-back, refill, update).
module multi_cache_miss_ctrl
  import mcm_pkg::*;
#(
  parameter  int unsigned N_CH      = N_CH_DEF,
  parameter  int unsigned BURST_LEN = BURST_LEN_DEF,
  localparam int unsigned CNT_W     = $clog2(BURST_LEN),
  localparam int unsigned ID_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            arstn,
  input  logic [N_CH-1:0] i_start_check,
  input  logic [N_CH-1:0] i_hit,
  input  logic [N_CH-1:0] i_dirty,
  input  logic            i_r_valid,
  input  logic            i_r_last,
  input  logic            i_b_resp,
  input  logic            i_err_clr,
  output logic [N_CH-1:0] o_stall,
  output logic [N_CH-1:0] o_lru_update,
  output logic [N_CH-1:0] o_block_write_en,
  output logic [N_CH-1:0] o_valid_update,
  output logic            o_start_read,
  output logic            o_start_write,
  output logic            o_addr_control,
  output logic [ID_W-1:0] o_grant_id,
  output logic            o_busy,
  output logic            o_burst_err
);

  state_e            state_q;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [ID_W-1:0]   grant_q, ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic [N_CH-1:0]   hit_now, miss_now, upd_oh, arb_gnt;
  logic [ID_W-1:0]   arb_id;
  logic              arb_valid;
  logic              beat, err_set;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req_i    (pending_q),
    .ptr_i    (ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id),
    .valid_o  (arb_valid)
  );

  assign hit_now  = i_start_check & i_hit;
  assign miss_now = i_start_check & ~i_hit & ~pending_q;

  always_comb begin
    upd_oh = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      upd_oh[i] = (state_q == S_UPDATE) && (grant_q == ID_W'(i));
    end
  end

  assign pending_d = (pending_q & ~upd_oh) | miss_now;

  // A short burst is caught on the last beat; a long one on the BURST_LEN-th
  // beat that arrives without last (the counter then wraps and waits on).
  assign beat    = (state_q == S_RD_WAIT) && i_r_valid;
  assign err_set = beat && (i_r_last ? (cnt_q != CNT_W'(BURST_LEN - 1))
                                     : (cnt_q == CNT_W'(BURST_LEN - 1)));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (err_set)        err_q <= 1'b1;
      else if (i_err_clr) err_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_id;
            state_q <= (|(i_dirty & arb_gnt)) ? S_WB_START : S_RD_START;
          end
        end
        S_WB_START: state_q <= S_WB_WAIT;
        S_WB_WAIT:  if (i_b_resp) state_q <= S_RD_START;
        S_RD_START: begin
          cnt_q   <= '0;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (i_r_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (i_r_last) state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          ptr_q   <= (grant_q == ID_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_stall          = pending_q | (i_start_check & ~i_hit);
  assign o_lru_update     = hit_now | upd_oh;
  assign o_block_write_en = upd_oh;
  assign o_valid_update   = upd_oh;
  assign o_start_read     = (state_q == S_RD_START);
  assign o_start_write    = (state_q == S_WB_START);
  assign o_addr_control   = (state_q == S_WB_START) || (state_q == S_WB_WAIT);
  assign o_grant_id       = grant_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_burst_err      = err_q;

endmodule

// File: tb/tb_multi_cache_miss_ctrl.sv
// Directed-vector bench for multi_cache_miss_ctrl with N_CH=2, BURST_LEN=4.
module tb_multi_cache_miss_ctrl;

  logic       clk = 1'b0;
  logic       arstn;
  logic [1:0] i_start_check, i_hit, i_dirty;
  logic       i_r_valid, i_r_last, i_b_resp, i_err_clr;
  logic [1:0] o_stall, o_lru_update, o_block_write_en, o_valid_update;
  logic       o_start_read, o_start_write, o_addr_control, o_busy, o_burst_err;
  logic [0:0] o_grant_id;

  multi_cache_miss_ctrl #(.N_CH(2), .BURST_LEN(4)) dut (
    .clk              (clk),
    .arstn            (arstn),
    .i_start_check    (i_start_check),
    .i_hit            (i_hit),
    .i_dirty          (i_dirty),
    .i_r_valid        (i_r_valid),
    .i_r_last         (i_r_last),
    .i_b_resp         (i_b_resp),
    .i_err_clr        (i_err_clr),
    .o_stall          (o_stall),
    .o_lru_update     (o_lru_update),
    .o_block_write_en (o_block_write_en),
    .o_valid_update   (o_valid_update),
    .o_start_read     (o_start_read),
    .o_start_write    (o_start_write),
    .o_addr_control   (o_addr_control),
    .o_grant_id       (o_grant_id),
    .o_busy           (o_busy),
    .o_burst_err      (o_burst_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sc, hit, dirty;
    logic rv, rl, br, ec;
  } in_t;

  typedef struct packed {
    logic [1:0] stall, lru, bwe, vu;
    logic sr, sw, ac, gid, busy, err;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic in_t ii(logic [1:0] sc, logic [1:0] hit, logic [1:0] dirty,
                             logic rv, logic rl, logic br);
    in_t x;
    x = '{sc, hit, dirty, rv, rl, br, 1'b0};
    return x;
  endfunction

  function automatic out_t oo(logic [1:0] stall, logic [1:0] lru, logic [1:0] bwe,
                              logic sr, logic sw, logic ac, logic gid, logic busy);
    out_t x;
    x = '{stall, lru, bwe, bwe, sr, sw, ac, gid, busy, 1'b0};
    return x;
  endfunction

  function automatic out_t sample();
    out_t x;
    x = '{o_stall, o_lru_update, o_block_write_en, o_valid_update, o_start_read,
          o_start_write, o_addr_control, o_grant_id[0], o_busy, o_burst_err};
    return x;
  endfunction

  task automatic add(in_t i, out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(in_t x);
    i_start_check = x.sc;
    i_hit         = x.hit;
    i_dirty       = x.dirty;
    i_r_valid     = x.rv;
    i_r_last      = x.rl;
    i_b_resp      = x.br;
    i_err_clr     = x.ec;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    drive('0);
    #1;
  endtask

  task automatic beats(int n, int last_at);
    for (int b = 1; b <= n; b++) begin
      i_r_valid = 1'b1;
      i_r_last  = (b == last_at);
      nxt();
    end
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    drive('0);
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // clean miss on ch1, with a ch0 hit mid-refill
    add(ii(2'b00, 2'b00, 2'b00, 0, 0, 0), oo(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    add(ii(2'b01, 2'b01, 2'b00, 0, 0, 0), oo(2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0));
    add(ii(2'b10, 2'b00, 2'b00, 0, 0, 0), oo(2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    add(ii(2'b00, 2'b00, 2'b00, 0, 0, 0), oo(2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    add(ii(2'b00, 2'b00, 2'b00, 0, 0, 0), oo(2'b10, 2'b00, 2'b00, 1, 0, 0, 1, 1));
    add(ii(2'b00, 2'b00, 2'b00, 1, 0, 0), oo(2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 1));
    add(ii(2'b01, 2'b01, 2'b00, 1, 0, 0), oo(2'b10, 2'b01, 2'b00, 0, 0, 0, 1, 1));
    add(ii(2'b00, 2'b00, 2'b00, 1, 0, 0), oo(2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 1));
    add(ii(2'b00, 2'b00, 2'b00, 1, 1, 0), oo(2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 1));
    add(ii(2'b00, 2'b00, 2'b00, 0, 0, 0), oo(2'b10, 2'b10, 2'b10, 0, 0, 0, 1, 1));
    add(ii(2'b00, 2'b00, 2'b00, 0, 0, 0), oo(2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    // dirty miss on ch0: write-back, b_resp 5 cycles after start_write, refill
    add(ii(2'b01, 2'b00, 2'b01, 0, 0, 0), oo(2'b01, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    add(ii(2'b00, 2'b00, 2'b01, 0, 0, 0), oo(2'b01, 2'b00, 2'b00, 0, 0, 0, 1, 0));
    add(ii(2'b00, 2'b00, 2'b01, 0, 0, 0), oo(2'b01, 2'b00, 2'b00, 0, 1, 1, 0, 1));
    for (int k = 0; k < 4; k++)
      add(ii(2'b00, 2'b00, 2'b01, 0, 0, 0), oo(2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 1));
    add(ii(2'b00, 2'b00, 2'b01, 0, 0, 1), oo(2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 1));
    add(ii(2'b00, 2'b00, 2'b00, 0, 0, 0), oo(2'b01, 2'b00, 2'b00, 1, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++)
      add(ii(2'b00, 2'b00, 2'b00, 1, 0, 0), oo(2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    add(ii(2'b00, 2'b00, 2'b00, 1, 1, 0), oo(2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    add(ii(2'b00, 2'b00, 2'b00, 0, 0, 0), oo(2'b01, 2'b01, 2'b01, 0, 0, 0, 0, 1));
    // stray b_resp in IDLE must not start anything
    add(ii(2'b00, 2'b00, 2'b00, 0, 0, 1), oo(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    add(ii(2'b00, 2'b00, 2'b00, 0, 0, 0), oo(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));

    arstn = 1'b0;
    drive('0);
    #1;
    chk("reset_outputs", 32'(sample()), 32'(0));
    repeat (2) @(negedge clk);
    arstn = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].i);
      #1;
      chk($sformatf("vec%0d", k), 32'(sample()), 32'(tbl[k].o));
    end

    // same-cycle misses: ch0 first, then ch1, then a ch0 re-miss from during ch1
    nxt();
    do_reset();
    i_start_check = 2'b11;
    #1 chk("arb_miss_stall", 32'(o_stall), 32'(2'b11));
    nxt();
    chk("arb_idle_busy", 32'(o_busy), 32'(0));
    nxt();
    chk("arb_first_id", 32'(o_grant_id), 32'(0));
    chk("arb_first_rd", 32'(o_start_read), 32'(1));
    nxt();
    beats(4, 4);
    chk("arb_upd_ch0", 32'(o_block_write_en), 32'(2'b01));
    chk("arb_upd_stall", 32'(o_stall), 32'(2'b11));
    nxt();
    nxt();
    chk("arb_second_id", 32'(o_grant_id), 32'(1));
    chk("arb_second_rd", 32'(o_start_read), 32'(1));
    i_start_check = 2'b01;
    #1 chk("arb_remiss_stall", 32'(o_stall), 32'(2'b11));
    nxt();
    beats(4, 4);
    chk("arb_upd_ch1", 32'(o_block_write_en), 32'(2'b10));
    nxt();
    nxt();
    chk("arb_third_id", 32'(o_grant_id), 32'(0));
    chk("arb_third_rd", 32'(o_start_read), 32'(1));
    nxt();
    beats(4, 4);
    chk("arb_upd_ch0b", 32'(o_block_write_en), 32'(2'b01));
    nxt();
    chk("arb_done", 32'({o_stall, o_busy}), 32'(0));

    // short burst: last on beat 2 of 4
    do_reset();
    i_start_check = 2'b10;
    #1;
    nxt();
    nxt();
    nxt();
    beats(2, 2);
    chk("short_err", 32'(o_burst_err), 32'(1));
    chk("short_upd", 32'(o_block_write_en), 32'(2'b10));
    nxt();
    chk("err_sticky", 32'(o_burst_err), 32'(1));
    i_err_clr = 1'b1;
    nxt();
    chk("err_cleared", 32'(o_burst_err), 32'(0));

    // long burst: 4th beat without last flags, even with a same-cycle clear
    i_start_check = 2'b01;
    #1;
    nxt();
    nxt();
    nxt();
    beats(3, 0);
    chk("long_no_err_yet", 32'(o_burst_err), 32'(0));
    i_r_valid = 1'b1;
    i_err_clr = 1'b1;
    nxt();
    chk("long_err_set_wins", 32'(o_burst_err), 32'(1));
    chk("long_still_busy", 32'(o_busy), 32'(1));
    beats(1, 1);
    chk("long_upd", 32'(o_block_write_en), 32'(2'b01));

    // reset in the middle of a refill
    nxt();
    do_reset();
    i_start_check = 2'b01;
    #1;
    nxt();
    nxt();
    nxt();
    beats(1, 0);
    i_r_valid = 1'b1;
    #2 arstn = 1'b0;
    #1 chk("midreset_outputs", 32'(sample()), 32'(0));
    @(negedge clk);
    arstn = 1'b1;
    drive('0);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("post_reset%0d", k), 32'(sample()), 32'(0));
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
